serial_byte_rx: RTL and testbench

- Receive-side counterpart of the board's serial byte transmitter.
- Recovers 8-bit bytes from a single asynchronous serial line: idle-high, one start bit (0), 8 data bits LSB-first, one stop bit (1).
- Presents each byte on a one-entry valid/ready holding register to the CPU core, e.g. for host-to-board console input.
- Also reports framing errors and overruns.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/rx_sync2.sv | 43 ++++
 rtl/serial_byte_rx.sv | 230 +++++++++++++++++++++++
 tb/tb_serial_byte_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the board's serial byte receiver and transmitter:
// receiver state encoding, frame geometry, line idle level and the default
// bit period for 115200 baud on the 50 MHz system clock.
// No ports (package).
// ---------------------------------------------------------------------------
package serial_pkg;

  localparam int   DATA_BITS           = 8;
  localparam logic LINE_IDLE           = 1'b1;
  localparam int   CLKS_PER_BIT_115200 = 434;   // 50 MHz / 115200

  // PARITY exists in every build; it is only reachable when the receiver
  // is built with parity checking enabled.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

endpackage

// File: rtl/rx_sync2.sv
// ---------------------------------------------------------------------------
// rx_sync2
// Two-flop synchronizer for a single asynchronous input (serial line, KEY
// buttons). Both flops reset to RESET_VAL so that no false edge is seen
// when reset is released.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous, active-high reset
//   d    in   asynchronous input
//   q    out  synchronized input
// ---------------------------------------------------------------------------
module rx_sync2 #(
  parameter logic RESET_VAL = serial_pkg::LINE_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/serial_byte_rx.sv
// ---------------------------------------------------------------------------
// serial_byte_rx
// Asynchronous serial receiver: idle-high line, 1 start bit, 8 data bits
// LSB first, 1 stop bit. Each received byte is offered on a one-entry
// valid/ready holding register. Framing errors and overruns are reported
// as single-cycle pulses.
//
// Build option: define SERIAL_RX_PARITY_EN to expect an even parity bit
// between the last data bit and the stop bit. A parity mismatch drops the
// byte and pulses frame_err once the stop bit has been sampled.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   rxd          in   asynchronous serial input, idle high
//   rx_data      out  received byte (stable while rx_valid and unconsumed)
//   rx_valid     out  rx_data holds an unconsumed byte
//   rx_ready     in   consumer takes rx_data this cycle when rx_valid=1
//   rx_busy      out  frame in progress (state != IDLE)
//   frame_err    out  1-cycle pulse: bad stop bit (or bad parity)
//   overrun_err  out  1-cycle pulse: completed byte dropped, register full
// ---------------------------------------------------------------------------
module serial_byte_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = serial_pkg::CLKS_PER_BIT_115200,
  parameter int DATA_BITS    = serial_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("serial_byte_rx: CLKS_PER_BIT must be 4 or more");
  end
  if (DATA_BITS != 8) begin : g_bad_data_bits
    $error("serial_byte_rx: DATA_BITS is fixed at 8");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic rxs;

  rx_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
`ifdef SERIAL_RX_PARITY_EN
  logic                 par_err_q, par_err_d;
`endif

  // Strobes from the frame FSM to the holding register, valid for one cycle
  // at the stop-bit sample.
  logic stop_ok;
  logic stop_bad;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef SERIAL_RX_PARITY_EN
      par_err_q     <= par_err_d;
`endif
    end
  end

  // ---------------- next-state logic ----------------
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_err_d = par_err_q;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs != LINE_IDLE) state_d = START;
      end

      START: begin
        // Mid-start-bit check rejects short glitches on the line.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxs != LINE_IDLE) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};   // LSB arrives first
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit carry an even count of 1s.
          par_err_d = ^{shreg_q, rxs};
          state_d   = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs == LINE_IDLE) begin
            stop_ok = 1'b1;
            state_d = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        // A line held low (break) must return high before a new start bit
        // is accepted.
        cnt_d = '0;
        if (rxs == LINE_IDLE) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------- output logic ----------------
  logic deliver;
  logic bad_frame;

  always_comb begin
`ifdef SERIAL_RX_PARITY_EN
    deliver   = stop_ok & ~par_err_q;
    bad_frame = stop_bad | (stop_ok & par_err_q);
`else
    deliver   = stop_ok;
    bad_frame = stop_bad;
`endif

    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    frame_err_d   = bad_frame;
    overrun_err_d = 1'b0;

    if (deliver) begin
      // A byte consumed in the same cycle frees the register for the new one.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_err_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    rx_busy = (state_q != IDLE);
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_serial_byte_rx
// Directed self-checking bench for serial_byte_rx with CLKS_PER_BIT=8.
// Inputs change on the falling clock edge; a monitor samples outputs 1 time
// unit after each rising edge and keeps running counts that the directed
// steps compare against hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_byte_rx;

  localparam int CPB = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam int LAT = 79 + 8;   // extra parity bit period
`else
  localparam int LAT = 79;       // 2 sync + 4 half bit + 72 data/stop + 1
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun_err;

  serial_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         valid_cycles = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         busy_low = 0;
  int         viol = 0;
  int         rise_cyc = 0;
  logic [7:0] rx_log[$];
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_ovr = 1'b0;
  logic       win = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1) begin
      valid_cycles++;
      if (prev_valid !== 1'b1) begin
        rise_cyc = cyc;
        rx_log.push_back(rx_data);
      end
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (overrun_err === 1'b1) ovr_cnt++;
    if ((frame_err === 1'b1 && overrun_err === 1'b1) ||
        (frame_err === 1'b1 && prev_ferr === 1'b1) ||
        (overrun_err === 1'b1 && prev_ovr === 1'b1)) viol++;
    if (win && rx_busy !== 1'b1) busy_low++;
    prev_valid = rx_valid;
    prev_ferr  = frame_err;
    prev_ovr   = overrun_err;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    tick(CPB);
  endtask

  int start_cyc = 0;

  // Whole frame; par_flip inverts the parity bit in parity builds.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef SERIAL_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored without parity build");
`endif
    drive_bit(stop_bit);
  endtask

  int n0, v0, f0, o0, b0;

  task automatic snap();
    n0 = rx_log.size();
    v0 = valid_cycles;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
    b0 = busy_low;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    check("reset_rx_data",     rx_data,     8'h00);
    check("reset_rx_valid",    rx_valid,    1'b0);
    check("reset_rx_busy",     rx_busy,     1'b0);
    check("reset_frame_err",   frame_err,   1'b0);
    check("reset_overrun_err", overrun_err, 1'b0);
    rst = 1'b0;
    tick(5);

    // Single frame 0x31, consumer always ready.
    snap();
    send_frame(8'h31, 1'b1, 1'b0);
    tick(4);
    check("f31_valid_cycles", valid_cycles - v0, 1);
    check("f31_data",         rx_log[n0],        8'h31);
    check("f31_latency",      rise_cyc - start_cyc, LAT);
    check("f31_no_ferr",      ferr_cnt - f0,     0);
    check("f31_no_ovr",       ovr_cnt - o0,      0);

    // Back-to-back 0x2E, 0x39. Busy is low for 2 cycles before the first
    // START, 4 cycles between frames and 2 after the last stop sample.
    snap();
    win = 1'b1;
    send_frame(8'h2E, 1'b1, 1'b0);
    send_frame(8'h39, 1'b1, 1'b0);
    win = 1'b0;
    tick(4);
    check("b2b_valid_cycles", valid_cycles - v0, 2);
    check("b2b_first",        rx_log[n0],        8'h2E);
    check("b2b_second",       rx_log[n0+1],      8'h39);
    check("b2b_busy_low",     busy_low - b0,     8);

    // Short glitch: 3 cycles low.
    snap();
    rxd = 1'b0;
    tick(3);
    check("glitch_busy_start", rx_busy, 1'b1);
    rxd = 1'b1;
    tick(20);
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_no_ferr",  ferr_cnt - f0,     0);
    check("glitch_idle",     rx_busy,           1'b0);

    // Bad stop bit, line held low (break), then a good frame.
    snap();
    send_frame(8'hA5, 1'b0, 1'b0);
    rxd = 1'b0;
    tick(20);
    check("break_ferr_once", ferr_cnt - f0,     1);
    check("break_no_valid",  valid_cycles - v0, 0);
    check("break_wait_idle", rx_busy,           1'b1);
    rxd = 1'b1;
    tick(4);
    check("break_released",  rx_busy,           1'b0);
    tick(4);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(4);
    check("after_break_data",  rx_log[n0],        8'h5A);
    check("after_break_valid", valid_cycles - v0, 1);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(4);
    check("ovr_data_kept", rx_data,       8'h11);
    check("ovr_valid",     rx_valid,      1'b1);
    check("ovr_pulse",     ovr_cnt - o0,  1);
    check("ovr_no_ferr",   ferr_cnt - f0, 0);
    rx_ready = 1'b1;
    tick(1);
    check("ovr_consumed",  rx_valid,      1'b0);

    // Reset in the middle of the data bits of 0x55.
    snap();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("midrst_busy_before", rx_busy, 1'b1);
    rst = 1'b1;
    rxd = 1'b1;
    tick(1);
    check("midrst_rx_data",     rx_data,     8'h00);
    check("midrst_rx_valid",    rx_valid,    1'b0);
    check("midrst_rx_busy",     rx_busy,     1'b0);
    check("midrst_frame_err",   frame_err,   1'b0);
    check("midrst_overrun_err", overrun_err, 1'b0);
    rst = 1'b0;
    tick(100);
    check("midrst_no_valid", valid_cycles - v0, 0);
    check("midrst_no_ferr",  ferr_cnt - f0,     0);
    check("midrst_idle",     rx_busy,           1'b0);

`ifdef SERIAL_RX_PARITY_EN
    snap();
    send_frame(8'h03, 1'b1, 1'b0);
    tick(4);
    check("par_ok_valid", valid_cycles - v0, 1);
    check("par_ok_data",  rx_log[n0],        8'h03);
    check("par_ok_ferr",  ferr_cnt - f0,     0);
    snap();
    send_frame(8'h03, 1'b1, 1'b1);
    tick(4);
    check("par_bad_ferr",  ferr_cnt - f0,     1);
    check("par_bad_valid", valid_cycles - v0, 0);
`endif

    check("pulse_rules", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
